// File: rtl/div_sequencer.sv
// ============================================================================
// div_sequencer: radix-2 restoring DIV/DIVU sequencer with pipeline stall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   shift_d;
  logic [WIDTH-1:0] sub_d;
  logic             take_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             last_d;

  assign a_neg = signed_div & a[WIDTH-1];
  assign b_neg = signed_div & b[WIDTH-1];
  assign a_abs = a_neg ? (~a + 1'b1) : a;
  assign b_abs = b_neg ? (~b + 1'b1) : b;

  // Shifted remainder can exceed WIDTH bits when the divisor is above 2^(WIDTH-1);
  // the modular WIDTH-bit subtraction is exact whenever the trial succeeds.
  assign shift_d = {rem_q, quo_q[WIDTH-1]};
  assign take_d  = (shift_d >= {1'b0, dvs_q});
  assign sub_d   = shift_d[WIDTH-1:0] - dvs_q;
  assign rem_d   = take_d ? sub_d : shift_d[WIDTH-1:0];
  assign quo_d   = {quo_q[WIDTH-2:0], take_d};
  assign last_d  = (cnt_q == CW'(WIDTH - 1));

  assign stall = start & ~cancel & (state_q != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      hi_o         <= '0;
      lo_o         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start & ~cancel) begin
            dvs_q  <= b_abs;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= a_abs;
            busy   <= 1'b1;
            if (b == '0) begin
              state_q      <= DONE;
              result_valid <= 1'b1;
              lo_o         <= {WIDTH{1'b1}};
              hi_o         <= a;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cancel) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_d) begin
              state_q      <= DONE;
              result_valid <= 1'b1;
              lo_o         <= qneg_q ? (~quo_d + 1'b1) : quo_d;
              hi_o         <= rneg_q ? (~rem_d + 1'b1) : rem_d;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// ============================================================================
// tb_div_sequencer: directed and random checks of div_sequencer against a
// plain-arithmetic quotient/remainder model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_div = 1'b0;
  logic         cancel = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         stall;
  logic         busy;
  logic         result_valid;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int           n_total = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .cancel(cancel), .a(a), .b(b), .stall(stall), .busy(busy),
    .result_valid(result_valid), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Truncating division done in 64-bit arithmetic, returns {remainder, quotient}.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx, sy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    sx = {{32{s & x[31]}}, x};
    sy = {{32{s & y[31]}}, y};
    q  = sx / sy;
    r  = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Called just after a rising edge; leaves just after the edge following DONE.
  task automatic run_div(input logic [31:0] x, input logic [31:0] y, input logic s, input bit keep);
    int          lat;
    logic [63:0] r;
    lat = (y == 32'd0) ? 1 : W + 1;
    r   = model(x, y, s);
    start = 1'b1; a = x; b = y; signed_div = s;
    for (int c = 0; c <= lat; c++) begin
      if (c >= 1 && c < lat) begin
        a = $urandom; b = $urandom; signed_div = 1'($urandom_range(0, 1));
      end else begin
        a = x; b = y; signed_div = s;
      end
      @(negedge clk);
      check("stall", stall, 64'(c < lat));
      check("valid", result_valid, 64'(c == lat));
      check("busy", busy, 64'(c >= 1));
      if (c == lat) begin
        check("hi", hi_o, r[63:32]);
        check("lo", lo_o, r[31:0]);
      end
      @(posedge clk); #1;
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    if (!keep) start = 1'b0;
  endtask

  task automatic idle_chk();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", result_valid, 0);
    check("idle_stall", stall, 0);
    check("hold_hi", hi_o, exp_hi);
    check("hold_lo", lo_o, exp_lo);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] x, y;
    logic        s;

    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_chk();

    run_div(32'd7, 32'd2, 1'b0, 1'b0);
    idle_chk();
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_div(32'd5, 32'd0, 1'b1, 1'b0);
    idle_chk();

    // Flush in cycle 10 of 100 / 3.
    start = 1'b1; a = 32'd100; b = 32'd3; signed_div = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) cancel = 1'b1;
      @(negedge clk);
      if (c == 10) check("cancel_stall", stall, 0);
      check("cancel_valid", result_valid, 0);
      @(posedge clk); #1;
    end
    cancel = 1'b0; start = 1'b0;
    repeat (3) idle_chk();
    run_div(32'd9, 32'd3, 1'b0, 1'b0);

    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Asynchronous reset in cycle 5 of 1 / 1.
    start = 1'b1; a = 32'd1; b = 32'd1; signed_div = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; start = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", result_valid, 0);
    check("arst_hi", hi_o, 0);
    check("arst_lo", lo_o, 0);
    exp_hi = '0; exp_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) idle_chk();

    run_div(32'd20, 32'd6, 1'b0, 1'b1);
    run_div(32'd20, 32'd6, 1'b0, 1'b0);
    idle_chk();

    for (int i = 0; i < 40; i++) begin
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      run_div(x, y, s, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_chk();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle divide controller that sequences a radix-2 restoring divider for DIV/DIVU in the execute stage. It accepts operands from the E-stage forwarding muxes and holds the pipeline via `stall` until the quotient and remainder are ready. It then presents `{hi_o, lo_o}` for one cycle so the HI/LO write path can commit them alongside `hilo_we`. Cancellation is supported for E-stage flushes.

## Interface
- `WIDTH`, default 32: operand width. It must be a power of two ≥ 4. The iteration counter is `$clog2(WIDTH)` bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  E-stage instruction is DIV/DIVU and is valid. Held high by the pipeline while stalled.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with `start` in IDLE.
- `cancel`  in  1  E-stage flush; aborts any division in progress.
- `a`  in  WIDTH  dividend (rs).
- `b`  in  WIDTH  divisor (rt).
- `stall`  out  1  combinational: `start & ~cancel & (state != DONE)`.
- `busy`  out  1  registered; 1 in BUSY and DONE.
- `result_valid`  out  1  1 only in DONE.
- `hi_o`  out  WIDTH  remainder.
- `lo_o`  out  WIDTH  quotient.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `start & ~cancel` captures `|a|`, `|b|`, the quotient sign (`a[W-1]^b[W-1]` when signed) and the remainder sign (`a[W-1]` when signed).
  - If `b != 0`: go to BUSY with counter = 0 and partial remainder = 0.
  - If `b == 0`: go straight to DONE with `lo_o = {WIDTH{1}}` and `hi_o = a` (raw, unsigned and signed alike).
- BUSY, per cycle:
  - Shift `{rem, quo}` left 1 and trial-subtract `|b|` from the upper half.
  - On a non-negative difference, keep it and set quotient bit = 1.
  - The counter increments each cycle. When the counter == WIDTH-1, the edge applies sign fix-up and loads `hi_o`/`lo_o`:
    - negate quotient if the quotient sign is set;
    - negate remainder if the remainder sign is set.
  - The state then goes to DONE.
- DONE: `result_valid` = 1 and `stall` = 0, so the pipeline advances. The state goes unconditionally to IDLE on the next edge. `start` seen in DONE never restarts the operation.
- `cancel` in BUSY or DONE goes to IDLE on the next edge; `result_valid` is never asserted for the aborted operation. `cancel` has priority over `start` in IDLE.
- `hi_o`/`lo_o` hold their last result until the next completed division. They are never updated on cancel.
- Signed overflow: `0x80000000 / 0xFFFFFFFF` gives `lo_o = 0x80000000`, `hi_o = 0`, with no exception.
- The block never writes HI/LO itself. The consumer gates the write with `result_valid`.

## Timing
- Reset (asynchronous) forces state IDLE, `busy = 0`, `result_valid = 0`, `hi_o = lo_o = 0`, and all internal registers to 0. `stall` follows its equation, so it is 0 while `start = 0`.
- Reset asserted mid-BUSY aborts immediately. No result is produced.
- Latency, nonzero divisor:
  - `start` is first seen in cycle 0 (IDLE).
  - BUSY occupies cycles 1..WIDTH.
  - DONE is cycle WIDTH+1.
  - `stall` is high in cycles 0..WIDTH (WIDTH+1 cycles) and low in cycle WIDTH+1.
- Latency, zero divisor: DONE in cycle 1; `stall` high only in cycle 0.
- Back-to-back divides: a new `start` is accepted in the IDLE cycle after DONE, so the minimum issue interval is WIDTH+2 cycles.
- Operand inputs are ignored after capture. Forwarding changes during BUSY have no effect.

## Test plan
- Unsigned 7 / 2 (WIDTH=32): `stall` high cycles 0..32; cycle 33 gives `result_valid = 1`, `lo_o = 3`, `hi_o = 1`; cycle 34 is IDLE with `busy = 0`.
- Signed −7 / 2 (`a = 0xFFFFFFF9`): cycle 33 gives `lo_o = 0xFFFFFFFD`, `hi_o = 0xFFFFFFFF`. Signed 7 / −2 gives `lo_o = 0xFFFFFFFD`, `hi_o = 1`.
- Divide by zero, `a = 5`, `b = 0` (signed): cycle 1 gives `result_valid = 1`, `lo_o = 0xFFFFFFFF`, `hi_o = 5`; `stall` is high only in cycle 0.
- Start 100 / 3, assert `cancel` in cycle 10: cycle 11 is IDLE with `busy = 0`; `result_valid` is never high; `hi_o`/`lo_o` keep their prior values. A following 9 / 3 yields `lo_o = 3`, `hi_o = 0` after 33 cycles.
- Signed `0x80000000 / 0xFFFFFFFF`: `lo_o = 0x80000000`, `hi_o = 0`. Then assert `rst` in cycle 5 of an unsigned 1 / 1: all outputs are 0 immediately and no `result_valid` follows.
- `start` held high through DONE and the following IDLE with the same operands: exactly one `result_valid` pulse until IDLE re-accepts, then a second full 33-cycle sequence runs.
